// File: rtl/i2c_tx_sr_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_tx_sr_if
// Description : Controller/bus-side signal bundle for the I2C slave-transmit
//               shift register. The master modport is the controller side,
//               and the slave modport is the shift register itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_tx_sr_if #(
  parameter int NUM_BITS = 8
);

  logic [NUM_BITS-1:0] tx_data;
  logic                load_data;
  logic                scl_rise;
  logic                scl_fall;
  logic                sda_in;
  logic                abort;
  logic                sda_out;
  logic                busy;
  logic                byte_done;
  logic                ack_received;

  modport master (
    output tx_data, load_data, scl_rise, scl_fall, sda_in, abort,
    input  sda_out, busy, byte_done, ack_received
  );

  modport slave (
    input  tx_data, load_data, scl_rise, scl_fall, sda_in, abort,
    output sda_out, busy, byte_done, ack_received
  );

endinterface
`default_nettype wire

// File: rtl/i2c_tx_sr.sv
`default_nettype none
// ============================================================================
// Module      : i2c_tx_sr
// Description : I2C slave-transmitter shift register. It serialises a byte
//               MSB-first onto SDA, and it changes SDA only after SCL falling
//               edges. It then releases SDA for the master's ACK bit, samples
//               that bit, and reports the result to the controller.
//               NUM_BITS must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_tx_sr #(
  parameter int NUM_BITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            n_rst,
  i2c_tx_sr_if.slave      bus
);

  localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CW-1:0] c_last = CW'(NUM_BITS - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_ACK_WAIT = 2'd3
  } state_t;

  state_t                r_state,   w_state;
  logic [CW-1:0]         r_bit_cnt, w_bit_cnt;
  logic [NUM_BITS-1:0]   r_shift,   w_shift;
  logic                  r_sda_out, w_sda_out;
  logic                  r_busy,    w_busy;
  logic                  r_byte_done, w_byte_done;
  logic                  r_ack,     w_ack;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sda_sync;
  logic                   w_rise;
  logic                   w_fall;

  // The SDA synchroniser idles high because the line is pulled up when it is released.
  generate
    if (SYNC_STAGES > 1) begin : g_sync_chain
      // Shift raw SDA through the synchroniser chain.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_sync <= '1;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.sda_in};
      end
    end else begin : g_sync_single
      // Use a single-flop synchroniser.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_sync <= '1;
        else        r_sync <= bus.sda_in;
      end
    end
  endgenerate

  assign w_sda_sync = r_sync[SYNC_STAGES-1];

  // Simultaneous rise and fall strobes are illegal, so the block treats them as no edge.
  assign w_rise = bus.scl_rise & ~bus.scl_fall;
  assign w_fall = bus.scl_fall & ~bus.scl_rise;

  // State and output registers. Reset releases SDA immediately without waiting for a clock.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_sda_out   <= 1'b1;
      r_busy      <= 1'b0;
      r_byte_done <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_bit_cnt   <= w_bit_cnt;
      r_shift     <= w_shift;
      r_sda_out   <= w_sda_out;
      r_busy      <= w_busy;
      r_byte_done <= w_byte_done;
      r_ack       <= w_ack;
    end
  end

  // Next-state logic: the transfer sequencer, with abort taking priority over everything else.
  always_comb begin
    w_state     = r_state;
    w_bit_cnt   = r_bit_cnt;
    w_shift     = r_shift;
    w_sda_out   = r_sda_out;
    w_byte_done = 1'b0;
    w_ack       = r_ack;

    if (bus.abort) begin
      w_state   = ST_IDLE;
      w_sda_out = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_sda_out = 1'b1;
          if (bus.load_data) begin
            w_shift = bus.tx_data;
            w_ack   = 1'b0;
            w_state = ST_ARMED;
          end
        end
        // SCL may still be high here, so the MSB waits for the next falling edge.
        ST_ARMED: begin
          w_sda_out = 1'b1;
          if (w_fall) begin
            w_sda_out = r_shift[NUM_BITS-1];
            w_bit_cnt = '0;
            w_state   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_fall) begin
            if (r_bit_cnt != c_last) begin
              w_shift   = {r_shift[NUM_BITS-2:0], 1'b0};
              w_sda_out = r_shift[NUM_BITS-2];
              w_bit_cnt = r_bit_cnt + c_one;
            end else begin
              w_sda_out = 1'b1;
              w_state   = ST_ACK_WAIT;
            end
          end
        end
        ST_ACK_WAIT: begin
          w_sda_out = 1'b1;
          if (w_rise) begin
            w_ack       = ~w_sda_sync;
            w_byte_done = 1'b1;
            w_state     = ST_IDLE;
          end
        end
        default: begin
          w_state   = ST_IDLE;
          w_sda_out = 1'b1;
        end
      endcase
    end

    w_busy = (w_state != ST_IDLE);
  end

  assign bus.sda_out      = r_sda_out;
  assign bus.busy         = r_busy;
  assign bus.byte_done    = r_byte_done;
  assign bus.ack_received = r_ack;

endmodule
`default_nettype wire
